// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch FSM states (IDLE, BUSY, KILL)
//   fetch_entry_t : prefetch FIFO payload {pc, inst}
//   word_align()  : clears the byte-offset bits of an address
package mips_fetch_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned WORD_BYTES       = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        KILL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries; pointers wrap modulo DEPTH.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   push, push_data   : write one entry (legal while full if pop is also set)
//   pop               : retire the head entry
//   flush             : empty the FIFO, takes priority over push/pop
//   head              : entry at the head (undefined when empty)
//   count/empty/full  : occupancy status
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  fetch_entry_t                   push_data,
    input  logic                           pop,
    input  logic                           flush,
    output fetch_entry_t                   head,
    output logic [$clog2(DEPTH + 1)-1:0]   count,
    output logic                           empty,
    output logic                           full
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage; contents need no reset because the head is qualified by empty
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads over a
// req/ack handshake, buffers returned words and hands them to decode.
// Optional macro IFETCH_MISALIGN_TRAP_EN: misaligned redirects raise
// fetch_misaligned and stall fetch instead of being silently aligned.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   mem_req/mem_addr               : read request and word address
//   mem_ack/mem_rdata              : request accepted, data valid same cycle
//   redirect_valid/redirect_pc     : flush and restart fetch
//   inst_valid/inst/inst_pc/
//   inst_pc_plus_4/inst_ready      : decode-side valid/ready interface
//   fetch_misaligned               : (macro only) sticky misaligned-redirect flag
module ifetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus_4,
    input  logic        inst_ready
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misaligned
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    fetch_state_e  state;
    fetch_state_e  state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_next;
    logic [31:0]   req_addr;
    logic [31:0]   req_addr_next;
    logic          misaligned;
    logic          misaligned_next;
    logic          redir_bad;
    logic [31:0]   redir_target;
    logic          push;
    logic          pop;
    logic          credit;
    logic [OW-1:0] occ_next;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  head;
    fetch_entry_t  push_data;

    assign redir_target = word_align(redirect_pc);

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign redir_bad = 1'b0;
`endif

    assign misaligned_next = redirect_valid ? redir_bad : misaligned;

    // Redirect kills any push or pop happening in the same cycle
    assign pop       = !fifo_empty && inst_ready && !redirect_valid;
    assign push      = (state == BUSY) && mem_ack && !redirect_valid && (!fifo_full || pop);
    assign push_data = '{pc: req_addr, inst: mem_rdata};

    // Occupancy after this edge; a new request needs a free slot for its data
    assign occ_next = redirect_valid ? '0 : OW'(fifo_count) + OW'(push) - OW'(pop);
    assign credit   = !misaligned_next && (occ_next < OW'(DEPTH));

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and fetch address selection
    always_comb begin
        state_next    = state;
        fetch_pc_next = redirect_valid ? redir_target : fetch_pc;
        req_addr_next = req_addr;
        case (state)
            IDLE: begin
                if (credit) begin
                    state_next    = BUSY;
                    req_addr_next = fetch_pc_next;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    if (!redirect_valid) fetch_pc_next = fetch_pc + 32'(WORD_BYTES);
                    if (credit) req_addr_next = fetch_pc_next;
                    else        state_next    = IDLE;
                end else if (redirect_valid) begin
                    // request cannot be withdrawn: keep it up and drop its data
                    state_next = KILL;
                end
            end
            KILL: begin
                if (mem_ack) begin
                    if (credit) begin
                        state_next    = BUSY;
                        req_addr_next = fetch_pc_next;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Fetch PC, request address and misalignment flag
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            req_addr   <= RESET_PC;
            misaligned <= 1'b0;
        end else begin
            fetch_pc   <= fetch_pc_next;
            req_addr   <= req_addr_next;
            misaligned <= misaligned_next;
        end
    end

    // Outputs decoded from registered state; head fields read zero when empty
    always_comb begin
        mem_req        = (state != IDLE);
        mem_addr       = req_addr;
        inst_valid     = !fifo_empty;
        inst           = '0;
        inst_pc        = '0;
        inst_pc_plus_4 = '0;
        if (!fifo_empty) begin
            inst           = head.inst;
            inst_pc        = head.pc;
            inst_pc_plus_4 = head.pc + 32'(WORD_BYTES);
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign fetch_misaligned = misaligned;
`endif

endmodule
